seg7_scan_driver: RTL and testbench

Parametrised, time-multiplexed driver for a bank of common-anode 7-segment digits sharing one active-low segment bus.
- Decodes the full hex range 0-F per digit.
- Adds per-digit decimal point, per-digit blanking, optional leading-zero suppression and an anti-ghosting guard interval.
- Sits between any 4-bit-per-digit value source (counters, status registers) and the board pins.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_hex_decode.sv | 11 +
 rtl/seg7_scan_driver.sv | 143 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared segment definitions for the 7-segment scan driver: bit positions
// on the segment bus and the hex glyph table (active-high, a..g).
package seg7_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Literal MSB lands on index 0, so each entry reads left to right as a..g.
  localparam logic [0:6] HEX_TABLE [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  function automatic logic [0:6] hex_to_seg(input logic [3:0] nibble);
    return HEX_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low a..g segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [0:6] seg_n
);

  assign seg_n = ~hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with per-frame snapshot,
// decimal points, blanking, leading-zero suppression and an anode guard gap.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  lz_suppress,
  output logic [0:7]            seg_n,
  output logic [DIGITS-1:0]     an_n,
  output logic                  frame_tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] snap;
  logic [DIGITS-1:0]   dp_snap;
  logic [DIGITS-1:0]   blank_snap;
  logic                lz_snap;

  logic cnt_last;
  logic idx_last;
  logic frame_start;
  logic in_guard;

  assign cnt_last    = (cnt == CNT_W'(SCAN_DIV - 1));
  assign idx_last    = (idx == IDX_W'(DIGITS - 1));
  assign frame_start = enable && (cnt == '0) && (idx == '0);
  assign in_guard    = (cnt < CNT_W'(GUARD));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (!enable) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt_last) begin
      cnt <= '0;
      idx <= idx_last ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Inputs are frozen once per frame so a mid-frame update cannot tear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap       <= '0;
      dp_snap    <= '0;
      blank_snap <= '0;
      lz_snap    <= 1'b0;
    end else if (frame_start) begin
      snap       <= value;
      dp_snap    <= dp_in;
      blank_snap <= blank_in;
      lz_snap    <= lz_suppress;
    end
  end

  logic [DIGITS-1:0] lz_mask;
  logic              higher_nonzero;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    lz_mask        = '0;
    higher_nonzero = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      higher_nonzero = higher_nonzero | (snap[4*i +: 4] != 4'd0);
      lz_mask[i]     = lz_snap & ~higher_nonzero;
    end
  end

  logic [3:0] nibble;
  logic       dp_sel;
  logic       blank_sel;
  logic       lz_sel;

  always_comb begin
    nibble    = '0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    lz_sel    = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nibble    = snap[4*i +: 4];
        dp_sel    = dp_snap[i];
        blank_sel = blank_snap[i];
        lz_sel    = lz_mask[i];
      end
    end
  end

  logic [0:6] digit_seg_n;

  seg7_hex_decode u_decode (
    .nibble (nibble),
    .seg_n  (digit_seg_n)
  );

  logic [0:7] seg_next;

  // A suppressed digit keeps its decimal point; a blanked digit does not.
  always_comb begin
    seg_next = '1;
    if (!blank_sel) begin
      if (!lz_sel) seg_next[SEG_A:SEG_G] = digit_seg_n;
      seg_next[SEG_DP] = ~dp_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n      <= '1;
      an_n       <= '1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_start;
      if (!enable || in_guard) begin
        seg_n <= '1;
        an_n  <= '1;
      end else begin
        seg_n <= seg_next;
        an_n  <= ~(DIGITS'(1) << idx);
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed scenarios plus random
// stimulus, all compared every cycle against a frame/slot arithmetic model.
module tb_seg7_scan_driver;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 8;
  localparam int GUARD    = 2;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        lz_suppress;
  logic [0:7]  seg_n;
  logic [3:0]  an_n;
  logic        frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .GUARD    (GUARD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .value       (value),
    .dp_in       (dp_in),
    .blank_in    (blank_in),
    .lz_suppress (lz_suppress),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .frame_tick  (frame_tick)
  );

  // Glyphs a..g, a written leftmost.
  localparam logic [6:0] GLYPH [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // Reference model: k counts enabled clock edges since the scan restarted.
  int          k;
  logic [15:0] m_value;
  logic [3:0]  m_dp;
  logic [3:0]  m_blank;
  logic        m_lz;
  logic [0:7]  exp_seg;
  logic [3:0]  exp_an;
  logic        exp_tick;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [0:7] model_digit(input int slot);
    logic [3:0] nib;
    logic [6:0] pat;
    if (m_blank[slot]) return 8'hFF;
    nib = 4'(m_value >> (4 * slot));
    pat = GLYPH[nib];
    if (m_lz && slot > 0 && (m_value >> (4 * slot)) == 16'd0) pat = 7'd0;
    return ~{pat, m_dp[slot]};
  endfunction

  task automatic model_update();
    int phase;
    int slot;
    if (!rst_n || !enable) begin
      k        = 0;
      exp_seg  = 8'hFF;
      exp_an   = 4'hF;
      exp_tick = 1'b0;
    end else begin
      phase    = k % SCAN_DIV;
      slot     = (k / SCAN_DIV) % DIGITS;
      exp_tick = (k % FRAME) == 0;
      if (exp_tick) begin
        m_value = value;
        m_dp    = dp_in;
        m_blank = blank_in;
        m_lz    = lz_suppress;
      end
      if (phase < GUARD) begin
        exp_seg = 8'hFF;
        exp_an  = 4'hF;
      end else begin
        exp_seg = model_digit(slot);
        exp_an  = 4'hF & ~(4'b0001 << slot);
      end
      k++;
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      model_update();
      @(negedge clk);
      check("seg_n", 32'(seg_n), 32'(exp_seg));
      check("an_n", 32'(an_n), 32'(exp_an));
      check("frame_tick", 32'(frame_tick), 32'(exp_tick));
    end
  endtask

  initial begin
    rst_n       = 1'b1;
    enable      = 1'b0;
    value       = '0;
    dp_in       = '0;
    blank_in    = '0;
    lz_suppress = 1'b0;
    k           = 0;
    m_value     = '0;
    m_dp        = '0;
    m_blank     = '0;
    m_lz        = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("reset_seg_n", 32'(seg_n), 32'hFF);
    check("reset_an_n", 32'(an_n), 32'hF);
    check("reset_frame_tick", 32'(frame_tick), 32'h0);
    @(negedge clk);
    run(2);

    // Scan of 1234: digit 0 lit with "4" from the third edge on.
    rst_n  = 1'b1;
    enable = 1'b1;
    value  = 16'h1234;
    run(3);
    check("digit0_glyph4", 32'(seg_n), 32'h99);
    check("digit0_anode", 32'(an_n), 32'hE);
    run(2 * FRAME - 3);

    // Every glyph on every digit.
    for (int n = 0; n < 16; n++) begin
      value = {4{4'(n)}};
      run(FRAME);
    end

    // Leading-zero suppression.
    lz_suppress = 1'b1;
    value       = 16'h0050;
    run(2 * FRAME);
    value = 16'h0000;
    dp_in = 4'b1000;
    run(2 * FRAME);
    lz_suppress = 1'b0;
    dp_in       = '0;

    // Decimal point and blanking.
    value    = 16'h8888;
    dp_in    = 4'b0100;
    blank_in = 4'b0001;
    run(2 * FRAME);
    dp_in    = '0;
    blank_in = '0;

    // Mid-frame value change must not tear the frame.
    value = 16'h1111;
    run(FRAME + 2 * SCAN_DIV + 3);
    value = 16'h2222;
    run(2 * FRAME);

    // Enable drop mid-slot, then async reset mid-slot.
    run(3);
    enable = 1'b0;
    run(3);
    enable = 1'b1;
    value  = 16'hABCD;
    run(FRAME + 5);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_seg_n", 32'(seg_n), 32'hFF);
    check("async_reset_an_n", 32'(an_n), 32'hF);
    check("async_reset_frame_tick", 32'(frame_tick), 32'h0);
    run(1);
    rst_n = 1'b1;
    value = 16'h5E70;
    run(2 * FRAME);

    // Random traffic with occasional enable drops.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0)
        value = 16'($urandom) >> (4 * $urandom_range(0, 4));
      if ($urandom_range(0, 15) == 0) begin
        dp_in       = 4'($urandom);
        blank_in    = 4'($urandom) & 4'($urandom) & 4'($urandom);
        lz_suppress = 1'($urandom);
      end
      enable = ($urandom_range(0, 199) != 0);
      run(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
